mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter sitting directly upstream of the SRAM controller. It accepts word requests from the instruction-fetch stage (read-only) and the memory-access stage (read/write) and serialises them into the controller's single `en`/`op`/`addr`/`data_i` command port. It captures the controller's `data_o` into a stable read-data register and returns a one-cycle acknowledge to the granted client. A combined stall output freezes the pipeline while any client waits.

## Interface
- `ADDR_W`, 18: word address width; matches `ADDR_BUS`.
- `DATA_W`, 16: data width; matches `DATA_BUS`.
- `clk_50MHz` in 1: system clock, 50 MHz; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch read request; held until `if_ack`.
- `if_addr` in ADDR_W: fetch address; stable while `if_req`.
- `if_rdata` out DATA_W: fetch read data; valid while `if_ack`=1.
- `if_ack` out 1: one-cycle completion pulse for fetch.
- `mem_req` in 1: data request; held until `mem_ack`.
- `mem_we` in 1: 1 = write, 0 = read; stable while `mem_req`.
- `mem_addr` in ADDR_W: data address.
- `mem_wdata` in DATA_W: write data.
- `mem_rdata` out DATA_W: read data; valid while `mem_ack`=1 for reads.
- `mem_ack` out 1: one-cycle completion pulse for data port.
- `stall_o` out 1: `(if_req & ~if_ack) | (mem_req & ~mem_ack)`; combinational from registered state.
- `ram_en` out 1: command strobe to the controller; one cycle per access.
- `ram_op` out 1: `RAM_RD`/`RAM_WR`.
- `ram_addr` out ADDR_W: command address.
- `ram_wdata` out DATA_W: write data to the controller's `data_i`.
- `ram_rdata` in DATA_W: controller's `data_o`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, in a 2-bit register.
- **IDLE**
  - If `mem_req`=1: grant MEM. Latch `ram_addr`←`mem_addr`, `ram_op`←(`mem_we` ? `RAM_WR` : `RAM_RD`), `ram_wdata`←`mem_wdata`. Go to ISSUE.
  - Else if `if_req`=1: grant IF. Latch `ram_addr`←`if_addr`, `ram_op`←`RAM_RD`. `ram_wdata` is unchanged. Go to ISSUE.
  - Else stay in IDLE.
  - Priority is fixed MEM > IF. A continuous `mem_req` starves IF by design, because the pipeline is already stalled on MEM.
- **ISSUE**: `ram_en`=1 for exactly this cycle. Go to WAIT.
- **WAIT**: `ram_en`=0. `ram_addr`, `ram_op` and `ram_wdata` are held. Go to DONE.
- **DONE**
  - Pulse the granted port's ack.
  - For a read, capture `ram_rdata` into the granted port's rdata register at the edge entering DONE.
  - Clear the grant. Go to IDLE.
- The rdata registers hold their value until the next read completes on the same port.
- A write never updates `mem_rdata`.
- `ram_addr`, `ram_op` and `ram_wdata` remain stable from ISSUE through DONE, so the controller drives the bus for the full write window.
- Requests that arrive while not in IDLE are not sampled. The client keeps `req` asserted and is served at the next IDLE.

## Timing
- Latency: `req` high in IDLE cycle T → `ram_en` in T+1 → `ack` in T+3. Four cycles per access, back-to-back included.
- Acks are registered and asserted only in DONE. `if_ack` and `mem_ack` are never both 1.
- Client protocol: the client samples `ack` at the edge that ends DONE. In the following IDLE cycle it presents its next request or drops `req`.
- Reset (`rst`=0 at a rising edge), from any state, including mid-access:
  - state←IDLE, grant cleared.
  - `ram_en`, `if_ack`, `mem_ack` ← 0.
  - `ram_op`←`RAM_RD`.
  - `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata` ← 0.
  - An access aborted by reset produces no ack.
- `stall_o` is 0 during reset. With `rst`=0 the state is IDLE and the acks are 0, so `stall_o` otherwise follows the requests directly.

## Structure
- `ADDR_BUS`, `DATA_BUS`, `RAM_RD` and `RAM_WR` come from the shared `define.v`. Add nothing else to it.
- State encodings are local parameters.
- Single module, no sub-modules. An arbitration helper is too small to justify splitting.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=18'h00010, controller model returns 16'hA5A5 → `ram_en` one cycle at T+1 with `ram_op`=`RAM_RD` and `ram_addr`=18'h00010; `if_ack`=1 with `if_rdata`=16'hA5A5 at T+3; `stall_o`=1 for T..T+2.
- Write: `mem_req`=1, `mem_we`=1, `mem_addr`=18'h3FFFF, `mem_wdata`=16'h1234 → `ram_op`=`RAM_WR`, `ram_wdata`=16'h1234 stable T+1..T+3; `mem_ack` at T+3; `mem_rdata` unchanged.
- Contention: `if_req` and `mem_req` both raised in the same IDLE cycle → MEM is served first with `mem_ack` at T+3; IF is granted at T+4 with `if_ack` at T+7.
- Back-to-back reads: the MEM client issues addresses 0, 1, 2 on consecutive acks → acks exactly 4 cycles apart; each `mem_rdata` matches the model; `ram_en` is never high on two consecutive cycles.
- Reset mid-access: `rst`=0 in WAIT → next cycle state is IDLE, `ram_en`=0, no ack, all rdata registers = 0. After `rst`=1 with `if_req` still held, the fetch completes normally 3 cycles later.
- Idle: no requests for 20 cycles → `ram_en`, both acks and `stall_o` stay 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-port SRAM command arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_BUS = 18;
  localparam int DATA_BUS = 16;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Client request/ack ports plus the SRAM controller command port.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_BUS,
  parameter int DATA_W = mem_arbiter_pkg::DATA_BUS
);
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_o;

  logic              ram_en;
  logic              ram_op;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Clients and the controller together form the master side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_o,
           ram_en, ram_op, ram_addr, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_o,
           ram_en, ram_op, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests (MEM > IF) onto one SRAM command port.
// Four cycles per access: grant in IDLE, ram_en in ISSUE, ack in DONE; waiting clients see stall_o.
module mem_arbiter #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_BUS,
  parameter int DATA_W = mem_arbiter_pkg::DATA_BUS
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  import mem_arbiter_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  grant_t            grant;
  logic [ADDR_W-1:0] addr_q;
  logic              op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.mem_req || bus.if_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command fields are latched only at grant so they stay put through DONE.
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      grant       <= GNT_NONE;
      addr_q      <= '0;
      op_q        <= RAM_RD;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (bus.mem_req) begin
          grant   <= GNT_MEM;
          addr_q  <= bus.mem_addr;
          op_q    <= bus.mem_we ? RAM_WR : RAM_RD;
          wdata_q <= bus.mem_wdata;
        end else if (bus.if_req) begin
          grant  <= GNT_IF;
          addr_q <= bus.if_addr;
          op_q   <= RAM_RD;
        end
      end
      if (state == S_WAIT && op_q == RAM_RD) begin
        if (grant == GNT_IF)  if_rdata_q  <= bus.ram_rdata;
        if (grant == GNT_MEM) mem_rdata_q <= bus.ram_rdata;
      end
      if (state == S_DONE) begin
        grant <= GNT_NONE;
      end
    end
  end

  always_comb begin
    bus.ram_en    = (state == S_ISSUE);
    bus.if_ack    = (state == S_DONE) && (grant == GNT_IF);
    bus.mem_ack   = (state == S_DONE) && (grant == GNT_MEM);
    bus.ram_addr  = addr_q;
    bus.ram_op    = op_q;
    bus.ram_wdata = wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.mem_rdata = mem_rdata_q;
    // Held low while rst is asserted even if clients keep requesting.
    bus.stall_o   = rst && ((bus.if_req && !bus.if_ack) || (bus.mem_req && !bus.mem_ack));
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level timing model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = ADDR_BUS;
  localparam int DW = DATA_BUS;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Unwritten controller words read back as a fixed function of the address.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5B5;
  endfunction

  // SRAM controller: accepts a write on the ram_en cycle, presents data_o by address.
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];
  always @(negedge clk) begin
    if (bus.ram_en && bus.ram_op == RAM_WR) ctl_mem[bus.ram_addr] = bus.ram_wdata;
    bus.ram_rdata = ctl_mem.exists(bus.ram_addr) ? ctl_mem[bus.ram_addr] : dflt(bus.ram_addr);
  end

  // Reference: a granted access started in cycle t0 has ram_en at t0+1 and ack at t0+3.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            m_valid = 0;
  bit            busy    = 0;
  bit            g_mem, g_we;
  bit            prev_en = 0;
  int            t0      = 0;
  int            cyc     = 0;
  logic [AW-1:0] m_addr;
  logic          m_op;
  logic [DW-1:0] m_wdata, m_if_rd, m_mem_rd, pend;

  always @(negedge clk) begin
    bit e_en, e_ia, e_ma, e_stall;
    e_en    = busy && (cyc == t0 + 1);
    e_ia    = busy && (cyc == t0 + 3) && !g_mem;
    e_ma    = busy && (cyc == t0 + 3) && g_mem;
    e_stall = rst && ((bus.if_req && !e_ia) || (bus.mem_req && !e_ma));
    if (m_valid) begin
      check("ram_en",    bus.ram_en,    e_en);
      check("if_ack",    bus.if_ack,    e_ia);
      check("mem_ack",   bus.mem_ack,   e_ma);
      check("stall_o",   bus.stall_o,   e_stall);
      check("ram_addr",  bus.ram_addr,  m_addr);
      check("ram_op",    bus.ram_op,    m_op);
      check("ram_wdata", bus.ram_wdata, m_wdata);
      check("if_rdata",  bus.if_rdata,  m_if_rd);
      check("mem_rdata", bus.mem_rdata, m_mem_rd);
      if (bus.ram_en) check("ram_en_gap", prev_en, 1'b0);
    end
    prev_en = bus.ram_en;

    if (!rst) begin
      m_valid  = 1;
      busy     = 0;
      m_addr   = '0;
      m_op     = RAM_RD;
      m_wdata  = '0;
      m_if_rd  = '0;
      m_mem_rd = '0;
    end else if (busy) begin
      if (cyc == t0 + 2 && !g_we) begin
        if (g_mem) m_mem_rd = pend;
        else       m_if_rd  = pend;
      end
      if (cyc == t0 + 3) busy = 0;
    end else if (bus.mem_req) begin
      busy   = 1; t0 = cyc; g_mem = 1; g_we = bus.mem_we;
      m_addr = bus.mem_addr;
      m_op   = bus.mem_we ? RAM_WR : RAM_RD;
      m_wdata = bus.mem_wdata;
      if (g_we) ref_mem[m_addr] = m_wdata;
      else      pend = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
    end else if (bus.if_req) begin
      busy   = 1; t0 = cyc; g_mem = 0; g_we = 0;
      m_addr = bus.if_addr;
      m_op   = RAM_RD;
      pend   = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit is_mem, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_mem ? bus.mem_ack : bus.if_ack) && n < 12);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 18'h3FFFF;
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit saw_if, saw_mem;
    rst = 1'b0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_en", bus.ram_en, 0);
    check("rst_op", bus.ram_op, RAM_RD);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    step(); rst = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", {bus.ram_en, bus.if_ack, bus.mem_ack, bus.stall_o}, 4'b0);
    end

    // Single fetch
    step(); bus.if_req = 1; bus.if_addr = 18'h00010;
    @(negedge clk); check("f_stall_t0", bus.stall_o, 1); check("f_en_t0", bus.ram_en, 0);
    @(negedge clk); check("f_en_t1", bus.ram_en, 1); check("f_addr_t1", bus.ram_addr, 18'h00010);
                    check("f_op_t1", bus.ram_op, RAM_RD);
    @(negedge clk); check("f_en_t2", bus.ram_en, 0); check("f_stall_t2", bus.stall_o, 1);
    @(negedge clk); check("f_ack_t3", bus.if_ack, 1); check("f_rdata_t3", bus.if_rdata, 16'hA5A5);
                    check("f_stall_t3", bus.stall_o, 0);

    // Write
    step(); bus.if_req = 0;
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 18'h3FFFF; bus.mem_wdata = 16'h1234;
    @(negedge clk); check("w_ack_t0", bus.mem_ack, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("w_op", bus.ram_op, RAM_WR);
      check("w_wdata", bus.ram_wdata, 16'h1234);
      check("w_addr", bus.ram_addr, 18'h3FFFF);
    end
    check("w_ack_t3", bus.mem_ack, 1);
    check("w_rdata_kept", bus.mem_rdata, 0);

    // Contention
    step(); bus.mem_we = 0; bus.mem_addr = 18'h5; bus.if_req = 1; bus.if_addr = 18'h6;
    wait_ack(1, n);
    check("c_mem_lat", n, 4); check("c_if_ack_t3", bus.if_ack, 0);
    check("c_mem_rdata", bus.mem_rdata, 16'hA5B0);
    step(); bus.mem_req = 0;
    wait_ack(0, n);
    check("c_if_lat", n, 4); check("c_if_rdata", bus.if_rdata, 16'hA5B3);

    // Back-to-back reads
    step(); bus.if_req = 0; bus.mem_req = 1; bus.mem_we = 0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_addr = AW'(k);
      wait_ack(1, n);
      check("b2b_lat", n, 4);
      check("b2b_rdata", bus.mem_rdata, dflt(AW'(k)));
      step();
    end
    bus.mem_req = 0;

    // Reset during WAIT
    step(); bus.if_req = 1; bus.if_addr = 18'h00020;
    step(); step(); rst = 1'b0;
    @(negedge clk); check("r_stall_in_rst", bus.stall_o, 0);
    step(); rst = 1'b1;
    @(negedge clk);
    check("r_en", bus.ram_en, 0); check("r_ack", bus.if_ack, 0);
    check("r_if_rdata", bus.if_rdata, 0); check("r_mem_rdata", bus.mem_rdata, 0);
    wait_ack(0, n);
    check("r_resume_lat", n, 3); check("r_resume_rdata", bus.if_rdata, 16'hA595);
    step(); bus.if_req = 0;

    // Random traffic with occasional resets
    saw_if = 0; saw_mem = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      saw_if  = bus.if_ack;
      saw_mem = bus.mem_ack;
      step();
      rst = ($urandom_range(0, 149) != 0);
      if (!bus.if_req || saw_if) begin
        bus.if_req = ($urandom_range(0, 2) != 0);
        if (bus.if_req) bus.if_addr = rand_addr();
      end
      if (!bus.mem_req || saw_mem) begin
        bus.mem_req = ($urandom_range(0, 2) == 0);
        if (bus.mem_req) begin
          bus.mem_we    = $urandom_range(0, 1) == 1;
          bus.mem_addr  = rand_addr();
          bus.mem_wdata = DW'($urandom);
        end
      end
    end
    rst = 1'b1; bus.if_req = 0; bus.mem_req = 0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
